csi_frame_buffer_scheduler: RTL and testbench
=============================================

// Module: csi_frame_buffer_scheduler
// PURPOSE
// - Sequences the CSI RX AXI write master across frames: latches frame config, computes Y/U/V plane base addresses.
// - Ping-pongs between frame_ptr0/frame_ptr1 when double buffering is enabled.
// - Tracks outstanding AXI write bursts; flags frame completion or dropped frames.
// - Sits between the CSI register file and the AXI write-address generator, in the AXI clock domain.
// PARAMETERS
// - ADDR_W      32  AXI address width / frame pointer width
// - DIM_W       16  frame_width / frame_height width
// - OUTST_W     8   outstanding-burst counter width (max 2^OUTST_W-1 bursts in flight)
// PORTS
// - axi_clk_i             in   1        AXI clock, sole clock
// - axi_reset_i           in   1        synchronous, active-high reset
// - csi_enable_i          in   1        CSI enable from register file
// - double_buff_enable_i  in   1        1 = alternate ptr0/ptr1 every completed frame
// - output_select_i       in   1        0 = single plane (U=V=Y base), 1 = YUV420 planar
// - frame_ptr0_i          in   ADDR_W   buffer 0 base
// - frame_ptr1_i          in   ADDR_W   buffer 1 base
// - frame_width_i         in   DIM_W    pixels per line
// - frame_height_i        in   DIM_W    lines per frame
// - frame_start_i         in   1        1-cycle pulse, frame start (sync'd to AXI domain)
// - frame_end_i           in   1        1-cycle pulse, last pixel of frame handed to AXI master
// - aw_hs_i               in   1        aw_valid & aw_ready of write master
// - b_hs_i                in   1        b_valid & b_ready of write master
// - y_base_o              out  ADDR_W   Y plane base of active frame
// - u_base_o              out  ADDR_W   U plane base
// - v_base_o              out  ADDR_W   V plane base
// - base_valid_o          out  1        bases stable, write master may issue AW
// - buf_idx_o             out  1        buffer in use (0 = ptr0, 1 = ptr1)
// - frame_done_o          out  1        1-cycle pulse, all B responses of frame received
// - frame_drop_o          out  1        1-cycle pulse, frame_start ignored
// - drop_cnt_o            out  16       saturating dropped-frame count
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, buf_idx 0, outstanding count 0.
// - FSM states: IDLE, ARMED, LATCH, ACTIVE, DRAIN.
// - IDLE -> ARMED when csi_enable_i=1. Any state -> IDLE when csi_enable_i=0;
//   outstanding count keeps tracking B responses and is not cleared.
// - ARMED -> LATCH on frame_start_i.
//   - Shadow-register width, height, output_select, ptr0, ptr1, double_buff.
//   - Register changes mid-frame do not affect the current frame.
// - LATCH (exactly 1 cycle):
//   - size = width*height, 2*DIM_W bits truncated to ADDR_W.
//   - base = buf_idx ? ptr1 : ptr0.
//   - y = base.
//   - Planar: u = base+size, v = u+(size>>2). Single plane: u = v = base.
//   - Addition wraps modulo 2^ADDR_W.
//   - -> ACTIVE; base_valid_o=1 the cycle after LATCH (2 cycles after frame_start_i).
// - ACTIVE: bases held constant; -> DRAIN on frame_end_i.
// - DRAIN -> ARMED when outstanding==0 (including same-cycle b_hs_i); that cycle:
//   - frame_done_o pulses and base_valid_o drops.
//   - buf_idx toggles if shadowed double_buff=1.
// - Outstanding counter: +1 on aw_hs_i, -1 on b_hs_i, unchanged when both in one cycle.
//   Saturates at max and at 0 (no wrap); underflow is a master bug.
// - frame_start_i in LATCH/ACTIVE/DRAIN:
//   - frame_drop_o pulses, drop_cnt_o +1 (saturates at 16'hFFFF).
//   - State, bases and buf_idx unchanged.
// - frame_start_i in IDLE or while csi_enable_i=0: ignored, not counted.
// - frame_end_i outside ACTIVE: ignored.
// - frame_start_i and frame_end_i together in ACTIVE: frame_end_i moves the FSM to DRAIN;
//   frame_start_i counts as a drop.
// STRUCTURE
// - csi_pkg:
//   - fsm_state_e (IDLE, ARMED, LATCH, ACTIVE, DRAIN).
//   - OUT_SEL_SINGLE / OUT_SEL_YUV420 constants.
//   - frame_cfg_t shadow struct {width, height, out_sel, ptr0, ptr1, dbuf}.
// - Sub-module csi_outstanding_counter: up/down saturating counter with is_zero output;
//   the rest is inline FSM + address datapath.
// TESTING
// - Reset W=H=512, ptr0=0, ptr1=0x0010_0000, planar, dbuf=1; pulse start:
//   -> buf0 y=0x0, u=0x4_0000, v=0x5_0000, base_valid 2 cycles after start.
// - 4 AW, 4 B, frame_end: frame_done one pulse after last B; next frame uses
//   y=0x10_0000, u=0x14_0000, v=0x15_0000.
// - Same with dbuf=0: second frame keeps buf_idx=0, y=0x0.
// - frame_start during ACTIVE and during DRAIN: frame_drop_o pulses twice, drop_cnt=2, bases unchanged.
// - frame_end with 3 outstanding, aw_hs & b_hs simultaneous for 5 cycles, then 3 B:
//   frame_done only after 3rd B.
// - csi_enable_i=0 in ACTIVE -> IDLE, base_valid_o=0 next cycle.
//   Re-enable: frame_start -> same buf_idx, fresh bases.
//   axi_reset_i mid-frame -> all outputs 0.

Source files
------------

// File: rtl/csi_pkg.sv
// rtl/csi_pkg.sv - shared types and constants for the CSI frame buffer scheduler
//
// Purpose: FSM state encoding, output-select constants and the frame
// configuration shadow struct shared by the scheduler and its testbench.
// Ports: none (package).
//
// frame_cfg_t is sized by CSI_ADDR_W / CSI_DIM_W; the scheduler's ADDR_W and
// DIM_W parameters are expected to stay equal to these.

package csi_pkg;

  localparam int CSI_ADDR_W = 32;
  localparam int CSI_DIM_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    LATCH  = 3'd2,
    ACTIVE = 3'd3,
    DRAIN  = 3'd4
  } fsm_state_e;

  localparam logic OUT_SEL_SINGLE = 1'b0;
  localparam logic OUT_SEL_YUV420 = 1'b1;

  typedef struct packed {
    logic [CSI_DIM_W-1:0]  width;
    logic [CSI_DIM_W-1:0]  height;
    logic                  out_sel;
    logic [CSI_ADDR_W-1:0] ptr0;
    logic [CSI_ADDR_W-1:0] ptr1;
    logic                  dbuf;
  } frame_cfg_t;

endpackage

// File: rtl/csi_outstanding_counter.sv
// rtl/csi_outstanding_counter.sv - saturating up/down counter of in-flight AXI write bursts
//
// Purpose: counts AW handshakes not yet answered by a B handshake.
// Ports:
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset
//   inc_i      in   AW handshake this cycle
//   dec_i      in   B handshake this cycle
//   is_zero_o  out  count after this cycle's handshakes is zero

module csi_outstanding_counter #(
  parameter int W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic is_zero_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Saturate at both ends; a B with nothing outstanding is a master bug and
  // must not wrap the count to full scale.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Look-ahead so the drain can finish on the same cycle as the last B.
  assign is_zero_o = (count_d == '0);

endmodule

// File: rtl/csi_frame_buffer_scheduler.sv
// rtl/csi_frame_buffer_scheduler.sv - per-frame base address sequencing for the CSI RX AXI write master
//
// Purpose: latches frame configuration at frame start, computes Y/U/V plane
// bases, ping-pongs between two frame buffers, tracks outstanding bursts and
// reports frame completion and dropped frame starts.
// Ports:
//   axi_clk_i / axi_reset_i        clock, synchronous active-high reset
//   csi_enable_i                   scheduler enable
//   double_buff_enable_i           alternate ptr0/ptr1 per completed frame
//   output_select_i                0 single plane, 1 YUV420 planar
//   frame_ptr0_i / frame_ptr1_i    buffer base addresses
//   frame_width_i / frame_height_i frame dimensions
//   frame_start_i / frame_end_i    frame boundary pulses
//   aw_hs_i / b_hs_i               write master AW and B handshakes
//   y_base_o / u_base_o / v_base_o plane bases of the active frame
//   base_valid_o                   bases stable
//   buf_idx_o                      buffer in use
//   frame_done_o / frame_drop_o    completion and drop pulses
//   drop_cnt_o                     saturating dropped-frame count

module csi_frame_buffer_scheduler
  import csi_pkg::*;
#(
  parameter int ADDR_W  = CSI_ADDR_W,
  parameter int DIM_W   = CSI_DIM_W,
  parameter int OUTST_W = 8
) (
  input  logic              axi_clk_i,
  input  logic              axi_reset_i,
  input  logic              csi_enable_i,
  input  logic              double_buff_enable_i,
  input  logic              output_select_i,
  input  logic [ADDR_W-1:0] frame_ptr0_i,
  input  logic [ADDR_W-1:0] frame_ptr1_i,
  input  logic [DIM_W-1:0]  frame_width_i,
  input  logic [DIM_W-1:0]  frame_height_i,
  input  logic              frame_start_i,
  input  logic              frame_end_i,
  input  logic              aw_hs_i,
  input  logic              b_hs_i,
  output logic [ADDR_W-1:0] y_base_o,
  output logic [ADDR_W-1:0] u_base_o,
  output logic [ADDR_W-1:0] v_base_o,
  output logic              base_valid_o,
  output logic              buf_idx_o,
  output logic              frame_done_o,
  output logic              frame_drop_o,
  output logic [15:0]       drop_cnt_o
);

  fsm_state_e        state_q, state_d;
  frame_cfg_t        cfg_q, cfg_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] u_q, u_d;
  logic [ADDR_W-1:0] v_q, v_d;
  logic              base_valid_q, base_valid_d;
  logic              buf_idx_q, buf_idx_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_drop_q, frame_drop_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              outst_zero;
  logic              drain_done;
  logic              start_dropped;

  logic [2*DIM_W-1:0] area;
  logic [ADDR_W-1:0]  size;
  logic [ADDR_W-1:0]  base_sel;
  logic [ADDR_W-1:0]  u_planar;

  csi_outstanding_counter #(
    .W (OUTST_W)
  ) u_outst (
    .clk_i     (axi_clk_i),
    .rst_i     (axi_reset_i),
    .inc_i     (aw_hs_i),
    .dec_i     (b_hs_i),
    .is_zero_o (outst_zero)
  );

  // Address datapath works only from the shadow copy, so register-file
  // writes during a frame never leak into its bases.
  assign area     = {{DIM_W{1'b0}}, cfg_q.width} * {{DIM_W{1'b0}}, cfg_q.height};
  assign size     = ADDR_W'(area);
  assign base_sel = buf_idx_q ? cfg_q.ptr1 : cfg_q.ptr0;
  assign u_planar = base_sel + size;

  assign drain_done    = csi_enable_i && (state_q == DRAIN) && outst_zero;
  assign start_dropped = csi_enable_i && frame_start_i &&
                         ((state_q == LATCH) || (state_q == ACTIVE) || (state_q == DRAIN));

  // State register
  always_ff @(posedge axi_clk_i) begin
    if (axi_reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; disable overrides every state.
  always_comb begin
    state_d = state_q;
    if (!csi_enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (frame_start_i) state_d = LATCH;
        LATCH:   state_d = ACTIVE;
        ACTIVE:  if (frame_end_i) state_d = DRAIN;
        DRAIN:   if (outst_zero) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    cfg_d        = cfg_q;
    y_d          = y_q;
    u_d          = u_q;
    v_d          = v_q;
    buf_idx_d    = buf_idx_q;
    drop_cnt_d   = drop_cnt_q;
    frame_done_d = drain_done;
    frame_drop_d = start_dropped;
    base_valid_d = (state_d == ACTIVE) || (state_d == DRAIN);

    if (csi_enable_i && (state_q == ARMED) && frame_start_i) begin
      cfg_d.width   = frame_width_i;
      cfg_d.height  = frame_height_i;
      cfg_d.out_sel = output_select_i;
      cfg_d.ptr0    = frame_ptr0_i;
      cfg_d.ptr1    = frame_ptr1_i;
      cfg_d.dbuf    = double_buff_enable_i;
    end

    if (state_q == LATCH) begin
      y_d = base_sel;
      if (cfg_q.out_sel == OUT_SEL_YUV420) begin
        u_d = u_planar;
        v_d = u_planar + (size >> 2);
      end else begin
        u_d = base_sel;
        v_d = base_sel;
      end
    end

    if (drain_done && cfg_q.dbuf) begin
      buf_idx_d = ~buf_idx_q;
    end

    if (start_dropped && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge axi_clk_i) begin
    if (axi_reset_i) begin
      cfg_q        <= '0;
      y_q          <= '0;
      u_q          <= '0;
      v_q          <= '0;
      base_valid_q <= 1'b0;
      buf_idx_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      cfg_q        <= cfg_d;
      y_q          <= y_d;
      u_q          <= u_d;
      v_q          <= v_d;
      base_valid_q <= base_valid_d;
      buf_idx_q    <= buf_idx_d;
      frame_done_q <= frame_done_d;
      frame_drop_q <= frame_drop_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign y_base_o     = y_q;
  assign u_base_o     = u_q;
  assign v_base_o     = v_q;
  assign base_valid_o = base_valid_q;
  assign buf_idx_o    = buf_idx_q;
  assign frame_done_o = frame_done_q;
  assign frame_drop_o = frame_drop_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_csi_frame_buffer_scheduler.sv
// tb/tb_csi_frame_buffer_scheduler.sv - self-checking bench for the CSI frame buffer scheduler

module tb_csi_frame_buffer_scheduler;

  logic        clk = 1'b0;
  logic        axi_reset;
  logic        csi_enable;
  logic        dbuf_en;
  logic        out_sel;
  logic [31:0] ptr0, ptr1;
  logic [15:0] width, height;
  logic        frame_start, frame_end, aw_hs, b_hs;
  logic [31:0] y_base, u_base, v_base;
  logic        base_valid, buf_idx, frame_done, frame_drop;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_buf;
  int          m_drops;
  logic [15:0] s_w, s_h;
  logic        s_sel, s_dbuf;
  logic [31:0] s_p0, s_p1;
  logic [31:0] ey, eu, ev;

  always #5 clk = ~clk;

  csi_frame_buffer_scheduler dut (
    .axi_clk_i            (clk),
    .axi_reset_i          (axi_reset),
    .csi_enable_i         (csi_enable),
    .double_buff_enable_i (dbuf_en),
    .output_select_i      (out_sel),
    .frame_ptr0_i         (ptr0),
    .frame_ptr1_i         (ptr1),
    .frame_width_i        (width),
    .frame_height_i       (height),
    .frame_start_i        (frame_start),
    .frame_end_i          (frame_end),
    .aw_hs_i              (aw_hs),
    .b_hs_i               (b_hs),
    .y_base_o             (y_base),
    .u_base_o             (u_base),
    .v_base_o             (v_base),
    .base_valid_o         (base_valid),
    .buf_idx_o            (buf_idx),
    .frame_done_o         (frame_done),
    .frame_drop_o         (frame_drop),
    .drop_cnt_o           (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected plane bases from the snapshot of the register inputs taken at frame start.
  task automatic calc_bases(input logic idx);
    longint unsigned sz, base, u;
    sz   = (longint'(s_w) * longint'(s_h)) % 64'h1_0000_0000;
    base = idx ? longint'(s_p1) : longint'(s_p0);
    ey   = base[31:0];
    if (s_sel) begin
      u  = (base + sz) % 64'h1_0000_0000;
      eu = u[31:0];
      ev = 32'((u + sz / 4) % 64'h1_0000_0000);
    end else begin
      eu = ey;
      ev = ey;
    end
  endtask

  task automatic snapshot();
    s_w = width; s_h = height; s_sel = out_sel;
    s_p0 = ptr0; s_p1 = ptr1; s_dbuf = dbuf_en;
  endtask

  task automatic do_reset();
    axi_reset = 1'b1; csi_enable = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    aw_hs = 1'b0; b_hs = 1'b0;
    tick(); tick();
    axi_reset = 1'b0;
    m_buf = 1'b0; m_drops = 0;
  endtask

  task automatic arm();
    csi_enable = 1'b1;
    tick();
  endtask

  // start pulse plus the LATCH cycle; bases are valid on return
  task automatic start_frame();
    snapshot();
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
  endtask

  task automatic set_cfg(input logic [15:0] w, input logic [15:0] h, input logic sel,
                         input logic [31:0] p0, input logic [31:0] p1, input logic db);
    width = w; height = h; out_sel = sel; ptr0 = p0; ptr1 = p1; dbuf_en = db;
  endtask

  task automatic test_reset();
    set_cfg(16'd512, 16'd512, 1'b1, 32'h0, 32'h0010_0000, 1'b1);
    do_reset();
    axi_reset = 1'b1; csi_enable = 1'b1; frame_start = 1'b1;
    tick();
    checks++;
    if ({y_base, u_base, v_base} !== 96'h0) begin
      errors++; $display("FAIL reset_bases y=%h u=%h v=%h expected 0", y_base, u_base, v_base);
    end
    checks++;
    if ({base_valid, buf_idx, frame_done, frame_drop} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {base_valid, buf_idx, frame_done, frame_drop});
    end
    checks++;
    if (drop_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_drop_cnt got %0d expected 0", drop_cnt);
    end
    frame_start = 1'b0;
    do_reset();
  endtask

  task automatic test_double_buffer();
    do_reset();
    set_cfg(16'd512, 16'd512, 1'b1, 32'h0, 32'h0010_0000, 1'b1);
    arm();
    snapshot();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checks++;
    if (base_valid !== 1'b0) begin
      errors++; $display("FAIL dbuf_valid_early got %b expected 0", base_valid);
    end
    tick();
    checks++;
    if (base_valid !== 1'b1 || buf_idx !== 1'b0) begin
      errors++; $display("FAIL dbuf_valid got valid=%b idx=%b expected 1 0", base_valid, buf_idx);
    end
    checks++;
    if (y_base !== 32'h0 || u_base !== 32'h0004_0000 || v_base !== 32'h0005_0000) begin
      errors++; $display("FAIL dbuf_frame0 y=%h u=%h v=%h expected 0 40000 50000", y_base, u_base, v_base);
    end
    aw_hs = 1'b1; repeat (4) tick(); aw_hs = 1'b0;
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    b_hs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (frame_done !== (i == 3)) begin
        errors++; $display("FAIL dbuf_done_b%0d got %b expected %b", i, frame_done, (i == 3));
      end
    end
    b_hs = 1'b0;
    checks++;
    if (base_valid !== 1'b0 || buf_idx !== 1'b1) begin
      errors++; $display("FAIL dbuf_after_done valid=%b idx=%b expected 0 1", base_valid, buf_idx);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL dbuf_done_pulse got %b expected 0", frame_done);
    end
    m_buf = 1'b1;
    start_frame();
    calc_bases(m_buf);
    checks++;
    if (y_base !== 32'h0010_0000 || u_base !== 32'h0014_0000 || v_base !== 32'h0015_0000 ||
        y_base !== ey || u_base !== eu || v_base !== ev) begin
      errors++; $display("FAIL dbuf_frame1 y=%h u=%h v=%h expected 100000 140000 150000", y_base, u_base, v_base);
    end
  endtask

  task automatic test_single_buffer();
    do_reset();
    set_cfg(16'd640, 16'd480, 1'b0, 32'h2000_0000, 32'h3000_0000, 1'b0);
    arm();
    for (int f = 0; f < 2; f++) begin
      start_frame();
      calc_bases(m_buf);
      checks++;
      if (buf_idx !== 1'b0 || y_base !== 32'h2000_0000 || u_base !== ey || v_base !== ev) begin
        errors++; $display("FAIL single_f%0d idx=%b y=%h u=%h v=%h expected 0 %h %h %h",
                           f, buf_idx, y_base, u_base, v_base, ey, eu, ev);
      end
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      tick();
      checks++;
      if (frame_done !== 1'b1 || buf_idx !== 1'b0) begin
        errors++; $display("FAIL single_done_f%0d done=%b idx=%b expected 1 0", f, frame_done, buf_idx);
      end
    end
  endtask

  task automatic test_drops();
    do_reset();
    set_cfg(16'd100, 16'd50, 1'b1, 32'h0100_0000, 32'h0200_0000, 1'b1);
    arm();
    start_frame();
    calc_bases(m_buf);
    aw_hs = 1'b1; tick(); aw_hs = 1'b0;
    ptr0 = 32'hDEAD_0000; width = 16'd7;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checks++;
    if (frame_drop !== 1'b1 || drop_cnt !== 16'd1 || y_base !== ey || u_base !== eu || v_base !== ev) begin
      errors++; $display("FAIL drop_active drop=%b cnt=%0d y=%h expected 1 1 %h", frame_drop, drop_cnt, y_base, ey);
    end
    tick();
    checks++;
    if (frame_drop !== 1'b0) begin
      errors++; $display("FAIL drop_pulse got %b expected 0", frame_drop);
    end
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checks++;
    if (frame_drop !== 1'b1 || drop_cnt !== 16'd2 || base_valid !== 1'b1 ||
        y_base !== ey || u_base !== eu || v_base !== ev || buf_idx !== 1'b0) begin
      errors++; $display("FAIL drop_drain drop=%b cnt=%0d valid=%b y=%h expected 1 2 1 %h",
                         frame_drop, drop_cnt, base_valid, y_base, ey);
    end
    b_hs = 1'b1; tick(); b_hs = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL drop_done got %b expected 1", frame_done);
    end
    m_buf = 1'b1;
    start_frame();
    calc_bases(m_buf);
    frame_start = 1'b1; frame_end = 1'b1; tick();
    frame_start = 1'b0; frame_end = 1'b0;
    checks++;
    if (frame_drop !== 1'b1 || drop_cnt !== 16'd3 || y_base !== ey) begin
      errors++; $display("FAIL drop_start_end drop=%b cnt=%0d y=%h expected 1 3 %h", frame_drop, drop_cnt, y_base, ey);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL drop_start_end_done got %b expected 1", frame_done);
    end
  endtask

  task automatic test_drain_overlap();
    do_reset();
    set_cfg(16'd64, 16'd64, 1'b1, 32'h0, 32'h1000, 1'b0);
    arm();
    start_frame();
    aw_hs = 1'b1; repeat (3) tick(); aw_hs = 1'b0;
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    aw_hs = 1'b1; b_hs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (frame_done !== 1'b0) begin
        errors++; $display("FAIL overlap_both%0d done=%b expected 0", i, frame_done);
      end
    end
    aw_hs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (frame_done !== (i == 2)) begin
        errors++; $display("FAIL overlap_b%0d done=%b expected %b", i, frame_done, (i == 2));
      end
    end
    b_hs = 1'b0;
  endtask

  task automatic test_disable_reenable();
    do_reset();
    set_cfg(16'd32, 16'd16, 1'b1, 32'h4000, 32'h8000, 1'b1);
    arm();
    start_frame();
    frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
    m_buf = 1'b1;
    start_frame();
    checks++;
    if (buf_idx !== 1'b1 || base_valid !== 1'b1) begin
      errors++; $display("FAIL dis_second idx=%b valid=%b expected 1 1", buf_idx, base_valid);
    end
    csi_enable = 1'b0; tick();
    checks++;
    if (base_valid !== 1'b0) begin
      errors++; $display("FAIL dis_valid got %b expected 0", base_valid);
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checks++;
    if (frame_drop !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL dis_start drop=%b cnt=%0d expected 0 0", frame_drop, drop_cnt);
    end
    ptr1 = 32'h0800_0000;
    arm();
    start_frame();
    calc_bases(m_buf);
    checks++;
    if (buf_idx !== 1'b1 || y_base !== 32'h0800_0000 || u_base !== eu || v_base !== ev) begin
      errors++; $display("FAIL reenable idx=%b y=%h u=%h v=%h expected 1 08000000 %h %h", buf_idx, y_base, u_base, v_base, eu, ev);
    end
    axi_reset = 1'b1; tick();
    checks++;
    if ({y_base, u_base, v_base, base_valid, buf_idx, frame_done, frame_drop, drop_cnt} !== 116'h0) begin
      errors++; $display("FAIL midframe_reset y=%h valid=%b idx=%b cnt=%0d expected all 0", y_base, base_valid, buf_idx, drop_cnt);
    end
    axi_reset = 1'b0;
  endtask

  task automatic test_random();
    int out, aw_left, guard;
    logic b, a, s;
    do_reset();
    arm();
    for (int f = 0; f < 25; f++) begin
      set_cfg(16'($urandom), 16'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
      start_frame();
      calc_bases(m_buf);
      checks++;
      if (base_valid !== 1'b1 || buf_idx !== m_buf || y_base !== ey || u_base !== eu || v_base !== ev) begin
        errors++; $display("FAIL rnd_bases f%0d idx=%b y=%h u=%h v=%h expected %b %h %h %h",
                           f, buf_idx, y_base, u_base, v_base, m_buf, ey, eu, ev);
      end
      out = 0;
      aw_left = $urandom_range(0, 5);
      while (aw_left > 0) begin
        a = 1'($urandom);
        b = (out > 0) && ($urandom_range(0, 2) == 0);
        s = ($urandom_range(0, 7) == 0);
        aw_hs = a; b_hs = b; frame_start = s;
        set_cfg(16'($urandom), 16'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
        tick();
        aw_hs = 1'b0; b_hs = 1'b0; frame_start = 1'b0;
        if (a) begin out++; aw_left--; end
        if (b) out--;
        if (s) m_drops++;
        checks++;
        if (frame_drop !== s || drop_cnt !== 16'(m_drops) || y_base !== ey || u_base !== eu || v_base !== ev) begin
          errors++; $display("FAIL rnd_active f%0d drop=%b cnt=%0d y=%h expected %b %0d %h",
                             f, frame_drop, drop_cnt, y_base, s, m_drops, ey);
        end
      end
      s = 1'($urandom);
      frame_end = 1'b1; frame_start = s; tick();
      frame_end = 1'b0; frame_start = 1'b0;
      if (s) m_drops++;
      checks++;
      if (frame_drop !== s || drop_cnt !== 16'(m_drops) || frame_done !== 1'b0) begin
        errors++; $display("FAIL rnd_end f%0d drop=%b cnt=%0d done=%b expected %b %0d 0",
                           f, frame_drop, drop_cnt, frame_done, s, m_drops);
      end
      guard = 0;
      forever begin
        b = (out > 0) && (guard > 20 || 1'($urandom));
        b_hs = b; tick(); b_hs = 1'b0;
        if (b) out--;
        guard++;
        checks++;
        if (frame_done !== (out == 0)) begin
          errors++; $display("FAIL rnd_drain f%0d done=%b expected %b outstanding=%0d", f, frame_done, (out == 0), out);
        end
        if (out == 0 || guard > 60) break;
      end
      if (s_dbuf) m_buf = ~m_buf;
      checks++;
      if (buf_idx !== m_buf || base_valid !== 1'b0) begin
        errors++; $display("FAIL rnd_after f%0d idx=%b valid=%b expected %b 0", f, buf_idx, base_valid, m_buf);
      end
    end
  endtask

  initial begin
    set_cfg(16'd0, 16'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    axi_reset = 1'b1; csi_enable = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    aw_hs = 1'b0; b_hs = 1'b0;
    test_reset();
    test_double_buffer();
    test_single_buffer();
    test_drops();
    test_drain_overlap();
    test_disable_reenable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
